// File: rtl/oddr_serializer_pkg.sv
// Shared definitions for the DDR output serializer: FSM encoding, reset
// synchronizer depth and the pair-counter width rule.
package oddr_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int RST_SYNC_STAGES = 3;

  // Pair counter indexes 0..data_w/2-1 and never shrinks below one bit.
  function automatic int cnt_width(input int data_w);
    int w;
    w = $clog2(data_w / 2);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ddr_out_cell.sv
// XOR-pair DDR output cell: a posedge and a negedge register whose XOR is the
// pad value, so no combinational mux ever sits on the clock.
module ddr_out_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic srval,
  input  logic d1,
  input  logic d2,
  output logic q
);

  logic rp_q, rp_d;
  logic rn_q, rn_d;

  // Each register stores its bit pre-XORed with the other so that q = rp ^ rn
  // equals d1 after the posedge and d2 after the negedge.
  always_comb begin
    rp_d = d1 ^ rn_q;
    rn_d = d2 ^ rp_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rp_q <= srval;
    else        rp_q <= rp_d;
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) rn_q <= 1'b0;
    else        rn_q <= rn_d;
  end

  assign q = rp_q ^ rn_q;

endmodule

// File: rtl/oddr_serializer.sv
// DDR output serializer: words enter a one-entry skid buffer over valid/ready,
// then leave two bits per clock from a shifter through an XOR DDR output cell.
module oddr_serializer
  import oddr_serializer_pkg::*;
#(
  parameter int   DATA_W        = 8,
  parameter logic LSB_FIRST     = 1'b1,
  parameter logic IS_C_INVERTED = 1'b0,
  parameter logic SRVAL         = 1'b0
) (
  input  logic              C,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] S_DATA,
  input  logic              S_VALID,
  output logic              S_READY,
  output logic              Q,
  output logic              BUSY,
  output logic              TX_LAST
);

  localparam int               PAIRS    = DATA_W / 2;
  localparam int               CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAIRS - 1);
  localparam int               NS       = RST_SYNC_STAGES;

  logic              clk_i;
  logic [NS-1:0]     sync_q, sync_d;
  logic              rst_int_n;
  logic              release_next;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] pend_q, pend_d;
  logic              pend_v_q, pend_v_d;
  logic              s_ready_q, s_ready_d;
  logic              busy_q, busy_d;
  logic              tx_last_q, tx_last_d;
  logic              d2_q, d2_d;
  logic              d1;
  logic              accept, load, last_pair;

  assign clk_i = C ^ IS_C_INVERTED;

  always_comb begin
    sync_d = {sync_q[NS-2:0], 1'b1};
  end

  always_ff @(posedge clk_i or negedge RST_N) begin
    if (!RST_N) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign rst_int_n    = sync_q[NS-1];
  assign release_next = sync_q[NS-2];

  // A word moves from pend into the shifter when idle or as the last pair
  // leaves, so back-to-back words follow each other with no idle half-cycles.
  always_comb begin
    accept    = S_VALID && s_ready_q;
    last_pair = (idx_q == LAST_IDX);
    load      = pend_v_q && ((state_q == ST_IDLE) || last_pair);

    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    if (load) begin
      state_d = ST_SHIFT;
      shift_d = pend_q;
      idx_d   = '0;
    end else if (state_q == ST_SHIFT) begin
      if (last_pair) begin
        state_d = ST_IDLE;
      end else begin
        shift_d = LSB_FIRST ? (shift_q >> 2) : (shift_q << 2);
        idx_d   = idx_q + 1'b1;
      end
    end

    pend_d   = accept ? S_DATA : pend_q;
    pend_v_d = accept || (pend_v_q && !load);

    s_ready_d = release_next && !pend_v_d;
    busy_d    = pend_v_d || (state_d == ST_SHIFT);
    tx_last_d = (state_d == ST_SHIFT) && (idx_d == LAST_IDX);

    // d1 must be valid at the same posedge that loads the pair, hence it is
    // taken from the next-state shifter; d2 is only needed at the negedge.
    if (state_d == ST_SHIFT) begin
      d1   = LSB_FIRST ? shift_d[0] : shift_d[DATA_W-1];
      d2_d = LSB_FIRST ? shift_d[1] : shift_d[DATA_W-2];
    end else begin
      d1   = SRVAL;
      d2_d = SRVAL;
    end
  end

  // Ready looks one synchronizer stage ahead so it rises on the same edge
  // that releases the internal reset.
  always_ff @(posedge clk_i or negedge RST_N) begin
    if (!RST_N) s_ready_q <= 1'b0;
    else        s_ready_q <= s_ready_d;
  end

  always_ff @(posedge clk_i or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
      pend_q    <= '0;
      pend_v_q  <= 1'b0;
      busy_q    <= 1'b0;
      tx_last_q <= 1'b0;
      d2_q      <= SRVAL;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      pend_v_q  <= pend_v_d;
      busy_q    <= busy_d;
      tx_last_q <= tx_last_d;
      d2_q      <= d2_d;
    end
  end

  ddr_out_cell u_cell (
    .clk   (clk_i),
    .rst_n (rst_int_n),
    .srval (SRVAL),
    .d1    (d1),
    .d2    (d2_q),
    .q     (Q)
  );

  assign S_READY = s_ready_q;
  assign BUSY    = busy_q;
  assign TX_LAST = tx_last_q;

endmodule

// File: tb/tb_oddr_serializer.sv
// Bench for oddr_serializer: two lanes (LSB/MSB first) checked each half-cycle
// against a word-timeline model, plus an inverted-clock SRVAL=1 instance.
module tb_oddr_serializer;

  localparam int W     = 8;
  localparam int PAIRS = W / 2;

  logic         C;
  logic         RST_N;
  logic [W-1:0] s_data, s_data2;
  logic         s_valid, s_valid2;
  logic         rdy0, q0, busy0, last0;
  logic         rdy1, q1, busy1, last1;
  logic         rdy2, q2, busy2, last2;

  int checks = 0;
  int errors = 0;
  int cyc, rel_cnt, nwords;
  logic [W-1:0] mword [64];
  int           macc   [64];
  int           mstart [64];
  logic [9:0]   obs;
  bit           last_hs;

  oddr_serializer #(.DATA_W(W), .LSB_FIRST(1'b1), .IS_C_INVERTED(1'b0), .SRVAL(1'b0)) dut0 (
    .C(C), .RST_N(RST_N), .S_DATA(s_data), .S_VALID(s_valid),
    .S_READY(rdy0), .Q(q0), .BUSY(busy0), .TX_LAST(last0));

  oddr_serializer #(.DATA_W(W), .LSB_FIRST(1'b0), .IS_C_INVERTED(1'b0), .SRVAL(1'b0)) dut1 (
    .C(C), .RST_N(RST_N), .S_DATA(s_data), .S_VALID(s_valid),
    .S_READY(rdy1), .Q(q1), .BUSY(busy1), .TX_LAST(last1));

  oddr_serializer #(.DATA_W(W), .LSB_FIRST(1'b1), .IS_C_INVERTED(1'b1), .SRVAL(1'b1)) dut2 (
    .C(C), .RST_N(RST_N), .S_DATA(s_data2), .S_VALID(s_valid2),
    .S_READY(rdy2), .Q(q2), .BUSY(busy2), .TX_LAST(last2));

  initial C = 1'b0;
  always #5 C = ~C;

  // Bit sent in a given half of a given pair; lane 1 is MSB first.
  function automatic logic exp_bit(int lane, logic [W-1:0] w, int pair, int half);
    int pos;
    pos = 2 * pair + half;
    if (lane == 1) pos = W - 1 - pos;
    return w[pos];
  endfunction

  // Every accepted word waits in the buffer until the earlier word has finished
  // (or one cycle, whichever is later) and then occupies PAIRS cycles.
  function automatic void model_accept(int t, logic [W-1:0] w);
    int st;
    st = t + 1;
    if (nwords > 0 && mstart[nwords-1] + PAIRS > st) st = mstart[nwords-1] + PAIRS;
    mword[nwords]  = w;
    macc[nwords]   = t;
    mstart[nwords] = st;
    nwords++;
  endfunction

  // {rdy0,rdy1,busy0,busy1,last0,last1,q0_pos,q1_pos,q0_neg,q1_neg} after posedge t.
  function automatic logic [9:0] expected_vec(int t);
    logic       rdy, busy, last;
    logic [3:0] q;
    rdy  = (rel_cnt >= 3);
    busy = 1'b0;
    last = 1'b0;
    q    = 4'b0000;
    for (int i = 0; i < nwords; i++) begin
      if (macc[i] <= t && t < mstart[i]) rdy = 1'b0;
      if (macc[i] <= t && t <= mstart[i] + PAIRS - 1) busy = 1'b1;
      if (t == mstart[i] + PAIRS - 1) last = 1'b1;
      if (t >= mstart[i] && t < mstart[i] + PAIRS)
        q = {exp_bit(0, mword[i], t - mstart[i], 0), exp_bit(1, mword[i], t - mstart[i], 0),
             exp_bit(0, mword[i], t - mstart[i], 1), exp_bit(1, mword[i], t - mstart[i], 1)};
    end
    return {rdy, rdy, busy, busy, last, last, q};
  endfunction

  task automatic step();
    bit hs;
    hs = s_valid && rdy0 && RST_N;
    @(posedge C);
    cyc++;
    if (RST_N && rel_cnt < 3) rel_cnt++;
    if (hs) model_accept(cyc, s_data);
    last_hs = hs;
    #1;
    obs[9:4] = {rdy0, rdy1, busy0, busy1, last0, last1};
    obs[3]   = q0;
    obs[2]   = q1;
    @(negedge C);
    #1;
    obs[1] = q0;
    obs[0] = q1;
  endtask

  task automatic test_reset();
    RST_N   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== expected_vec(cyc)) begin
        errors++;
        $display("[TB] FAIL reset_hold cyc=%0d got %b want %b", cyc, obs, expected_vec(cyc));
      end
    end
    checks++;
    if (q2 !== 1'b1 || rdy2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_inv_srval got q=%b rdy=%b want q=1 rdy=0", q2, rdy2);
    end
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== expected_vec(cyc) || rdy0 !== (i == 2)) begin
        errors++;
        $display("[TB] FAIL reset_release edge=%0d got %b want %b", i + 1, obs, expected_vec(cyc));
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_single_word();
    int         k;
    logic [7:0] seq0, seq1;
    k       = -1;
    seq0    = '0;
    seq1    = '0;
    s_data  = 8'hB4;
    s_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (last_hs) begin
        s_valid = 1'b0;
        k = cyc;
      end
      checks++;
      if (obs !== expected_vec(cyc)) begin
        errors++;
        $display("[TB] FAIL single_word cyc=%0d got %b want %b", cyc, obs, expected_vec(cyc));
      end
      if (k >= 0 && cyc > k && cyc <= k + PAIRS) begin
        seq0 = {seq0[5:0], obs[3], obs[1]};
        seq1 = {seq1[5:0], obs[2], obs[0]};
      end
    end
    checks++;
    if (seq0 !== 8'b00101101) begin
      errors++;
      $display("[TB] FAIL single_word_lsb_halves got %b want 00101101", seq0);
    end
    checks++;
    if (seq1 !== 8'b10110100) begin
      errors++;
      $display("[TB] FAIL single_word_msb_halves got %b want 10110100", seq1);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    n       = 0;
    s_data  = 8'hFF;
    s_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      if (last_hs) begin
        n++;
        if (n == 1) s_data = 8'h00;
        else        s_valid = 1'b0;
      end
      checks++;
      if (obs !== expected_vec(cyc)) begin
        errors++;
        $display("[TB] FAIL back_to_back cyc=%0d got %b want %b", cyc, obs, expected_vec(cyc));
      end
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("[TB] FAIL back_to_back_accepts got %0d want 2", n);
    end
  endtask

  task automatic test_random();
    int sent;
    sent    = 0;
    s_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!s_valid && sent < 20 && $urandom_range(0, 3) != 0) begin
        s_data  = W'($urandom);
        s_valid = 1'b1;
      end
      step();
      if (last_hs) begin
        sent++;
        s_valid = 1'b0;
      end
      checks++;
      if (obs !== expected_vec(cyc)) begin
        errors++;
        $display("[TB] FAIL random cyc=%0d got %b want %b", cyc, obs, expected_vec(cyc));
      end
      if (sent == 20 && cyc > mstart[nwords-1] + PAIRS) break;
    end
    checks++;
    if (sent != 20) begin
      errors++;
      $display("[TB] FAIL random_timeout sent %0d want 20", sent);
    end
  endtask

  task automatic test_reset_mid_word();
    bit hs;
    s_data  = 8'hA5;
    s_valid = 1'b1;
    for (int i = 0; i < 10 && !last_hs; i++) begin
      step();
      checks++;
      if (obs !== expected_vec(cyc)) begin
        errors++;
        $display("[TB] FAIL midword_pre cyc=%0d got %b want %b", cyc, obs, expected_vec(cyc));
      end
    end
    s_data = 8'h3C;
    step();
    hs = s_valid && rdy0;
    @(posedge C);
    cyc++;
    if (hs) model_accept(cyc, s_data);
    #1;
    s_valid = 1'b0;
    checks++;
    if ({q0, q1, busy0, rdy0} !== 4'b1110) begin
      errors++;
      $display("[TB] FAIL midword_pair1 got %b want 1110", {q0, q1, busy0, rdy0});
    end
    RST_N = 1'b0;
    #1;
    checks++;
    if ({q0, q1, busy0, rdy0, last0} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL midword_reset_immediate got %b want 00000", {q0, q1, busy0, rdy0, last0});
    end
    nwords  = 0;
    rel_cnt = 0;
    @(negedge C);
    #1;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) RST_N = 1'b1;
      step();
      checks++;
      if (obs !== expected_vec(cyc)) begin
        errors++;
        $display("[TB] FAIL midword_after cyc=%0d got %b want %b", cyc, obs, expected_vec(cyc));
      end
    end
  endtask

  task automatic test_inverted();
    logic [W-1:0] w;
    int           waited;
    w      = 8'hB4;
    waited = 0;
    while (rdy2 !== 1'b1 && waited < 10) begin
      @(negedge C);
      #1;
      waited++;
    end
    @(posedge C);
    #1;
    checks++;
    if (q2 !== 1'b1 || busy2 !== 1'b0 || rdy2 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL inv_idle got q=%b busy=%b rdy=%b want 1 0 1", q2, busy2, rdy2);
    end
    s_data2  = w;
    s_valid2 = 1'b1;
    @(negedge C);
    #1;
    s_valid2 = 1'b0;
    checks++;
    if (busy2 !== 1'b1 || q2 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL inv_accept got busy=%b q=%b want 1 1", busy2, q2);
    end
    for (int j = 0; j < PAIRS; j++) begin
      @(negedge C);
      #1;
      checks++;
      if (q2 !== w[2*j] || last2 !== (j == PAIRS - 1)) begin
        errors++;
        $display("[TB] FAIL inv_pair_d1 pair=%0d got q=%b last=%b want q=%b", j, q2, last2, w[2*j]);
      end
      @(posedge C);
      #1;
      checks++;
      if (q2 !== w[2*j+1]) begin
        errors++;
        $display("[TB] FAIL inv_pair_d2 pair=%0d got %b want %b", j, q2, w[2*j+1]);
      end
    end
    @(negedge C);
    #1;
    checks++;
    if (q2 !== 1'b1 || busy2 !== 1'b0 || last2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL inv_return_idle got q=%b busy=%b last=%b want 1 0 0", q2, busy2, last2);
    end
  endtask

  initial begin
    RST_N    = 1'b1;
    s_valid  = 1'b0;
    s_data   = '0;
    s_valid2 = 1'b0;
    s_data2  = '0;
    cyc      = 0;
    rel_cnt  = 0;
    nwords   = 0;
    last_hs  = 1'b0;
    #1;
    RST_N = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_random();
    last_hs = 1'b0;
    test_reset_mid_word();
    test_inverted();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
